// File: rtl/relay_pkg.sv
// Shared definitions for the skid-buffer relay station: stage state encoding
// and the count-width helper used to size the occupancy counter.
package relay_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    // Width needed to hold 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/relay_skid_stage.sv
// One 2-entry skid-buffer stage; in_ready and out_valid come straight from
// flops so neighbouring stages can be placed far apart.
module relay_skid_stage
    import relay_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  in_ce,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  out_ce
);

    stage_state_t          state;
    logic [DATA_WIDTH-1:0] main_reg;
    logic [DATA_WIDTH-1:0] skid_reg;
    logic                  push;
    logic                  pop;

    assign push = in_valid & in_ready & in_ce;
    assign pop  = out_valid & out_ready & out_ce;
    assign dout = main_reg;

    // Handshake flops track the state so they always equal (state != TWO) and (state != EMPTY).
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (pop && !push) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Payload registers carry no reset; only the valid state matters after reset.
    always_ff @(posedge clk) begin
        case (state)
            EMPTY: begin
                if (push) main_reg <= din;
            end
            ONE: begin
                if (push && pop)  main_reg <= din;
                else if (push)    skid_reg <= din;
            end
            TWO: begin
                if (pop) main_reg <= skid_reg;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/relay_station_skid.sv
// Multi-level relay station: a chain of skid stages plus an occupancy count
// and a registered almost-full flag for the producer.
module relay_station_skid
    import relay_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEVEL      = 2,
    parameter int AF_MARGIN  = 1,
    parameter int CNT_WIDTH  = clog2_min1(2 * LEVEL + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_almost_full_n,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [CNT_WIDTH-1:0]  if_count
);

    localparam int DEPTH = 2 * LEVEL;

    generate
        if (LEVEL == 0) begin : g_pass
            assign if_full_n        = if_read;
            assign if_empty_n       = if_write;
            assign if_dout          = if_din;
            assign if_count         = '0;
            assign if_almost_full_n = 1'b1;
        end else begin : g_chain
            logic [LEVEL:0]        valid;
            logic [LEVEL:0]        ready;
            logic [DATA_WIDTH-1:0] data [0:LEVEL];
            logic                  ext_push;
            logic                  ext_pop;
            logic [CNT_WIDTH-1:0]  count_reg;
            logic [CNT_WIDTH-1:0]  count_next;
            logic                  af_n_reg;

            assign valid[0]     = if_write;
            assign data[0]      = if_din;
            assign ready[LEVEL] = if_read;

            // Only the outer ends are gated by the clock enables; internal hops always flow.
            for (genvar s = 0; s < LEVEL; s++) begin : g_stage
                relay_skid_stage #(
                    .DATA_WIDTH(DATA_WIDTH)
                ) u_stage (
                    .clk       (clk),
                    .reset     (reset),
                    .in_valid  (valid[s]),
                    .in_ready  (ready[s]),
                    .din       (data[s]),
                    .in_ce     ((s == 0) ? if_write_ce : 1'b1),
                    .out_valid (valid[s+1]),
                    .out_ready (ready[s+1]),
                    .dout      (data[s+1]),
                    .out_ce    ((s == LEVEL - 1) ? if_read_ce : 1'b1)
                );
            end

            assign if_full_n  = ready[0];
            assign if_empty_n = valid[LEVEL];
            assign if_dout    = data[LEVEL];

            assign ext_push = if_write & ready[0] & if_write_ce;
            assign ext_pop  = valid[LEVEL] & if_read & if_read_ce;

            always_comb begin
                count_next = count_reg;
                if (ext_push && !ext_pop)
                    count_next = count_reg + CNT_WIDTH'(1);
                else if (ext_pop && !ext_push)
                    count_next = count_reg - CNT_WIDTH'(1);
            end

            // Almost-full is derived from the next count so it lines up with if_count.
            always_ff @(posedge clk) begin
                if (reset) begin
                    count_reg <= '0;
                    af_n_reg  <= (AF_MARGIN < DEPTH) ? 1'b1 : 1'b0;
                end else begin
                    count_reg <= count_next;
                    af_n_reg  <= (DEPTH - int'(count_next)) > AF_MARGIN;
                end
            end

            assign if_count         = count_reg;
            assign if_almost_full_n = af_n_reg;
        end
    endgenerate

endmodule

// File: tb/tb_relay_station_skid.sv
// Directed bench for relay_station_skid: vector table on a 2-level station,
// plus latency/streaming (3 levels), backpressure, reset and pass-through cases.
module tb_relay_station_skid;

    typedef struct {
        logic       wr;
        logic       wce;
        logic [7:0] din;
        logic       rd;
        logic       rce;
        logic       full_n;
        logic       empty_n;
        logic       chk_dout;
        logic [7:0] dout;
        int         count;
        logic       af_n;
    } vec_t;

    logic clk;
    logic reset;

    logic       a_full_n, a_write_ce, a_write, a_af_n, a_empty_n, a_read_ce, a_read;
    logic [7:0] a_din, a_dout;
    logic [2:0] a_count;

    logic       b_full_n, b_write_ce, b_write, b_af_n, b_empty_n, b_read_ce, b_read;
    logic [7:0] b_din, b_dout;
    logic [2:0] b_count;

    logic       z_full_n, z_write_ce, z_write, z_af_n, z_empty_n, z_read_ce, z_read;
    logic [7:0] z_din, z_dout;
    logic [0:0] z_count;

    int checks = 0;
    int passes = 0;

    relay_station_skid #(.DATA_WIDTH(8), .LEVEL(2), .AF_MARGIN(1)) u_l2 (
        .clk(clk), .reset(reset), .if_full_n(a_full_n), .if_write_ce(a_write_ce),
        .if_write(a_write), .if_din(a_din), .if_almost_full_n(a_af_n),
        .if_empty_n(a_empty_n), .if_read_ce(a_read_ce), .if_read(a_read),
        .if_dout(a_dout), .if_count(a_count)
    );

    relay_station_skid #(.DATA_WIDTH(8), .LEVEL(3), .AF_MARGIN(1)) u_l3 (
        .clk(clk), .reset(reset), .if_full_n(b_full_n), .if_write_ce(b_write_ce),
        .if_write(b_write), .if_din(b_din), .if_almost_full_n(b_af_n),
        .if_empty_n(b_empty_n), .if_read_ce(b_read_ce), .if_read(b_read),
        .if_dout(b_dout), .if_count(b_count)
    );

    relay_station_skid #(.DATA_WIDTH(8), .LEVEL(0), .AF_MARGIN(0)) u_l0 (
        .clk(clk), .reset(reset), .if_full_n(z_full_n), .if_write_ce(z_write_ce),
        .if_write(z_write), .if_din(z_din), .if_almost_full_n(z_af_n),
        .if_empty_n(z_empty_n), .if_read_ce(z_read_ce), .if_read(z_read),
        .if_dout(z_dout), .if_count(z_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected)
            passes++;
        else
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
    endtask

    // Occupancy must stay within 0..2*LEVEL on every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            check_output("l2_count_range", int'(a_count <= 3'd4), 1);
            check_output("l3_count_range", int'(b_count <= 3'd6), 1);
        end
    end

    task automatic apply_stimulus(input vec_t v, input int idx);
        a_write    = v.wr;
        a_write_ce = v.wce;
        a_din      = v.din;
        a_read     = v.rd;
        a_read_ce  = v.rce;
        @(posedge clk);
        #1;
        check_output($sformatf("vec%0d_full_n", idx), a_full_n, v.full_n);
        check_output($sformatf("vec%0d_empty_n", idx), a_empty_n, v.empty_n);
        check_output($sformatf("vec%0d_count", idx), a_count, v.count);
        check_output($sformatf("vec%0d_af_n", idx), a_af_n, v.af_n);
        if (v.chk_dout)
            check_output($sformatf("vec%0d_dout", idx), a_dout, v.dout);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    vec_t      vecs [15];
    logic [7:0] q [$];
    int        sent;
    int        recv;
    int        found;

    initial begin
        // wr wce din rd rce | full_n empty_n chk dout count af_n
        vecs[0]  = '{1, 1, 8'h11, 0, 1, 1, 0, 0, 8'h00, 1, 1};
        vecs[1]  = '{1, 1, 8'h22, 0, 1, 1, 1, 1, 8'h11, 2, 1};
        vecs[2]  = '{1, 1, 8'h33, 0, 1, 1, 1, 1, 8'h11, 3, 0};
        vecs[3]  = '{1, 1, 8'h44, 0, 1, 0, 1, 1, 8'h11, 4, 0};
        vecs[4]  = '{1, 1, 8'h55, 0, 1, 0, 1, 1, 8'h11, 4, 0};
        vecs[5]  = '{1, 1, 8'h55, 1, 1, 0, 1, 1, 8'h22, 3, 0};
        vecs[6]  = '{1, 1, 8'h55, 1, 1, 1, 1, 1, 8'h33, 2, 1};
        vecs[7]  = '{1, 1, 8'h55, 1, 1, 1, 1, 1, 8'h44, 2, 1};
        vecs[8]  = '{0, 1, 8'h00, 1, 1, 1, 1, 1, 8'h55, 1, 1};
        vecs[9]  = '{0, 1, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0, 1};
        vecs[10] = '{1, 0, 8'h66, 0, 1, 1, 0, 0, 8'h00, 0, 1};
        vecs[11] = '{1, 1, 8'h66, 0, 1, 1, 0, 0, 8'h00, 1, 1};
        vecs[12] = '{0, 1, 8'h00, 1, 0, 1, 1, 1, 8'h66, 1, 1};
        vecs[13] = '{0, 1, 8'h00, 1, 0, 1, 1, 1, 8'h66, 1, 1};
        vecs[14] = '{0, 1, 8'h00, 1, 1, 1, 0, 0, 8'h00, 0, 1};

        reset = 1'b1;
        {a_write, a_write_ce, a_read, a_read_ce, a_din} = '0;
        {b_write, b_write_ce, b_read, b_read_ce, b_din} = '0;
        {z_write, z_write_ce, z_read, z_read_ce, z_din} = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        check_output("rst_full_n", a_full_n, 1);
        check_output("rst_empty_n", a_empty_n, 0);
        check_output("rst_count", a_count, 0);
        check_output("rst_af_n", a_af_n, 1);
        check_output("rst_l3_af_n", b_af_n, 1);

        // Fill, hold, drain and clock-enable gating on the 2-level station.
        for (int i = 0; i < 15; i++)
            apply_stimulus(vecs[i], i);

        // Random backpressure against a queue scoreboard.
        q.delete();
        sent = 0;
        recv = 0;
        a_write_ce = 1'b1;
        a_read_ce  = 1'b1;
        for (int cyc = 0; cyc < 6000 && recv < 1000; cyc++) begin
            a_write = (sent < 1000);
            a_din   = 8'(sent);
            a_read  = 1'($urandom_range(0, 1));
            if (a_read && a_empty_n) begin
                if (q.size() == 0)
                    check_output("bp_underflow", 0, 1);
                else
                    check_output("bp_data", a_dout, q.pop_front());
                recv++;
            end
            if (a_write && a_full_n) begin
                q.push_back(8'(sent));
                sent++;
            end
            @(posedge clk);
            #1;
            check_output("bp_count", a_count, q.size());
        end
        a_write = 1'b0;
        a_read  = 1'b0;
        check_output("bp_received", recv, 1000);

        // Reset with three words queued; the next word written must be the first read.
        a_write = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            a_din = 8'(i);
            @(posedge clk);
            #1;
        end
        a_write = 1'b0;
        check_output("pre_rst_count", a_count, 3);
        pulse_reset();
        check_output("midrst_empty_n", a_empty_n, 0);
        check_output("midrst_count", a_count, 0);
        check_output("midrst_full_n", a_full_n, 1);
        check_output("midrst_af_n", a_af_n, 1);
        a_write = 1'b1;
        a_din   = 8'h77;
        @(posedge clk);
        #1;
        a_write = 1'b0;
        a_read  = 1'b1;
        found   = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            if (a_empty_n) found = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check_output("midrst_word_seen", found, 1);
        if (found == 1)
            check_output("midrst_first_word", a_dout, 8'h77);
        @(posedge clk);
        #1;
        a_read = 1'b0;

        // Latency through three empty stages, then a continuous stream.
        b_write_ce = 1'b1;
        b_read_ce  = 1'b1;
        b_read     = 1'b1;
        b_write    = 1'b1;
        b_din      = 8'hA5;
        @(posedge clk);
        #1;
        b_write = 1'b0;
        check_output("lat_edge1_empty_n", b_empty_n, 0);
        @(posedge clk);
        #1;
        check_output("lat_edge2_empty_n", b_empty_n, 0);
        @(posedge clk);
        #1;
        check_output("lat_edge3_empty_n", b_empty_n, 1);
        check_output("lat_edge3_dout", b_dout, 8'hA5);
        for (int k = 0; k < 12; k++) begin
            b_write = 1'b1;
            b_din   = 8'(8'hB0 + k);
            @(posedge clk);
            #1;
            check_output("stream_full_n", b_full_n, 1);
            if (k >= 2) begin
                check_output("stream_count", b_count, 3);
                check_output("stream_empty_n", b_empty_n, 1);
                check_output("stream_dout", b_dout, 8'hB0 + k - 2);
            end
        end
        b_write = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check_output("stream_drained", b_count, 0);
        b_read = 1'b0;

        // Zero-level station is a plain wire with ready/valid crossed over.
        z_din   = 8'h5A;
        z_write = 1'b1;
        z_read  = 1'b0;
        #1;
        check_output("l0_dout", z_dout, 8'h5A);
        check_output("l0_empty_n", z_empty_n, 1);
        check_output("l0_full_n", z_full_n, 0);
        check_output("l0_count", z_count, 0);
        check_output("l0_af_n", z_af_n, 1);
        z_read = 1'b1;
        #1;
        check_output("l0_full_n_read", z_full_n, 1);
        z_write = 1'b0;
        #1;
        check_output("l0_empty_n_idle", z_empty_n, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
